// File: rtl/cpu_prog_sequencer.sv
// Initiator side of the cpu start/wait handshake: issues words from a small program memory, one per cpu w cycle.
// Optional HALT_ON_V_EN: a run stops early on the first instruction that ends with V=1.
module cpu_prog_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          go,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
    output logic          busy,
    output logic          done,
    output logic          halted,
    output logic          err,
    output logic [AW-1:0] pc,
    output logic [2:0]    status
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem [DEPTH];
    logic [LW-1:0]   len_q, len_d, len_eff_c;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   pc_d;
    logic [15:0]     cpu_in_d;
    logic [2:0]      status_d;
    logic            done_d, err_d, halted_d, busy_d, load_d, s_d;
    logic            last_c, halt_c;

    // Requested length clamps to the memory size; the run compares pc against the value latched at go.
    assign len_eff_c = (32'(prog_len) > DEPTH) ? LW'(DEPTH) : prog_len;
    assign last_c    = ({1'b0, pc} + LW'(1)) == len_q;

`ifdef HALT_ON_V_EN
    assign halt_c = cpu_V;
`else
    assign halt_c = 1'b0;
`endif

    // Program memory: writable only between runs, not reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy && (32'(prog_addr) < DEPTH)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pc_d     = pc;
        status_d = status;
        done_d   = done;
        err_d    = err;
        halted_d = halted;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    halted_d = 1'b0;
                    pc_d     = '0;
                    len_d    = len_eff_c;
                    if (len_eff_c == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: begin
                state_d = S_WAIT_LO;
                cnt_d   = '0;
            end
            S_WAIT_LO, S_WAIT_HI: begin
                // Completion wins over a timeout landing on the same cycle.
                if (state_q == S_WAIT_HI && cpu_w) begin
                    status_d = {cpu_N, cpu_V, cpu_Z};
                    if (last_c || halt_c) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        halted_d = halt_c;
                    end else begin
                        pc_d    = pc + AW'(1);
                        state_d = S_LOAD;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (state_q == S_WAIT_LO && !cpu_w) begin
                        state_d = S_WAIT_HI;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_LOAD) || (state_d == S_START) ||
                   (state_d == S_WAIT_LO) || (state_d == S_WAIT_HI);
        load_d   = (state_d == S_LOAD) || (state_d == S_START);
        s_d      = (state_d == S_START);
        cpu_in_d = cpu_in;
        if (state_d == S_LOAD) begin
            cpu_in_d = mem[pc_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            pc       <= '0;
            status   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            halted   <= 1'b0;
            busy     <= 1'b0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            cpu_in   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            pc       <= pc_d;
            status   <= status_d;
            done     <= done_d;
            err      <= err_d;
            halted   <= halted_d;
            busy     <= busy_d;
            cpu_load <= load_d;
            cpu_s    <= s_d;
            cpu_in   <= cpu_in_d;
        end
    end

endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Randomized bench for cpu_prog_sequencer: stub cpu with scripted latencies/flags/stalls,
// checked against a run-level model of which instructions issue and how the run ends.
module tb_cpu_prog_sequencer;
    localparam int unsigned DEPTH   = 12;
    localparam int unsigned AW      = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int          NRUNS   = 40;
`ifdef HALT_ON_V_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, prog_we, go;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [AW:0]   prog_len;
    logic [15:0]   cpu_in;
    logic          cpu_load, cpu_s, cpu_w, cpu_N, cpu_V, cpu_Z;
    logic          busy, done, halted, err;
    logic [AW-1:0] pc;
    logic [2:0]    status;

    always #5 clk = ~clk;

    cpu_prog_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .go(go), .cpu_in(cpu_in),
        .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w), .cpu_N(cpu_N),
        .cpu_V(cpu_V), .cpu_Z(cpu_Z), .busy(busy), .done(done), .halted(halted),
        .err(err), .pc(pc), .status(status)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: memory image, last captured flags, per-instruction stub script.
    logic [15:0] ref_mem [DEPTH];
    logic [2:0]  ref_status;
    int          plan_mode [DEPTH];   // 0 normal, 1 never drops w, 2 never raises w
    int          plan_d1 [DEPTH];
    int          plan_d2 [DEPTH];
    logic [2:0]  plan_flags [DEPTH];
    logic [16:0] seen [$];            // {cpu_load, cpu_in} for every cycle cpu_s is high
    bit          stub_busy = 1'b0;

    initial forever begin
        @(posedge clk); #1;
        if (cpu_s) seen.push_back({cpu_load, cpu_in});
    end

    // Stub cpu: after a start pulse drop w, then raise it with the scripted flags.
    initial begin
        int idx;
        cpu_w = 1'b1;
        {cpu_N, cpu_V, cpu_Z} = 3'b000;
        forever begin
            @(posedge clk); #1;
            if (cpu_s) begin
                stub_busy = 1'b1;
                idx = int'(pc);
                repeat (plan_d1[idx]) begin @(posedge clk); #1; end
                if (plan_mode[idx] != 1) cpu_w = 1'b0;
                if (plan_mode[idx] == 0) begin
                    repeat (plan_d2[idx]) begin @(posedge clk); #1; end
                    {cpu_N, cpu_V, cpu_Z} = plan_flags[idx];
                    cpu_w = 1'b1;
                end else begin
                    repeat (TIMEOUT + 4) begin @(posedge clk); #1; end
                    cpu_w = 1'b1;
                end
                stub_busy = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_stub_idle();
        int cyc = 0;
        while (stub_busy && cyc < 100) begin cycle(); cyc++; end
        check("stub_idle", 32'(stub_busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_in"}, 32'(cpu_in), 32'd0);
        check({tag, "_cpu_load"}, 32'(cpu_load), 32'd0);
        check({tag, "_cpu_s"}, 32'(cpu_s), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_status"}, 32'(status), 32'd0);
    endtask

    task automatic mem_write(input logic [AW-1:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        if (!busy && 32'(a) < DEPTH) ref_mem[a] = d;
        cycle();
        prog_we = 1'b0;
    endtask

    task automatic make_plan(input bit allow_stall);
        for (int i = 0; i < int'(DEPTH); i++) begin
            plan_mode[i]  = (allow_stall && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            plan_d1[i]    = int'($urandom_range(0, 2));
            plan_d2[i]    = int'($urandom_range(2, 3));
            plan_flags[i] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                             1'($urandom_range(0, 1))};
        end
    endtask

    // One run: predict the issued count and end state from the script, then drive go and compare.
    task automatic do_run(input int len, input string tag);
        int leff, exp_n, exp_pc, cyc;
        bit exp_err, exp_halt;
        leff = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        exp_n = 0; exp_pc = 0; exp_err = 0; exp_halt = 0;
        for (int i = 0; i < leff; i++) begin
            exp_n++;
            exp_pc = i;
            if (plan_mode[i] != 0) begin exp_err = 1; break; end
            ref_status = plan_flags[i];
            if (HALT_EN && plan_flags[i][1]) begin exp_halt = 1; break; end
        end

        seen.delete();
        prog_len = (AW + 1)'(len);
        go = 1'b1;
        cycle();
        go = 1'b0;
        if (leff == 0) begin
            check({tag, "_len0_done"}, 32'(done), 32'd1);
        end else begin
            check({tag, "_go_busy"}, 32'(busy), 32'd1);
            check({tag, "_go_cpu_in"}, 32'(cpu_in), 32'(ref_mem[0]));
        end

        // While busy, stray writes and go pulses must have no effect.
        cyc = 0;
        while (!done && cyc < 500) begin
            if (busy && $urandom_range(0, 3) == 0) begin
                prog_we   = 1'b1;
                prog_addr = AW'($urandom_range(0, 15));
                prog_data = 16'($urandom);
                go        = 1'($urandom_range(0, 1));
            end
            cycle();
            prog_we = 1'b0;
            go      = 1'b0;
            cyc++;
        end

        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
        check({tag, "_status"}, 32'(status), 32'(ref_status));
        if (leff != 0) check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check({tag, "_pulses"}, 32'(seen.size()), 32'(exp_n));
        for (int k = 0; k < exp_n && k < seen.size(); k++) begin
            check({tag, "_issued"}, 32'(seen[k]), 32'({1'b1, ref_mem[k]}));
        end
        wait_stub_idle();
        repeat (3) cycle();
        check({tag, "_no_extra_pulse"}, 32'(seen.size()), 32'(exp_n));
        check({tag, "_done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        int n0;
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; go = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            plan_mode[i] = 0; plan_d1[i] = 0; plan_d2[i] = 2; plan_flags[i] = 3'b000;
        end
        repeat (3) cycle();
        check_reset_outputs("reset");
        reset = 1'b0;
        ref_status = 3'b000;

        // Fill the whole address space; addresses at or beyond DEPTH are dropped.
        for (int a = 0; a < 16; a++) mem_write(AW'(a), 16'($urandom));

        for (int r = 0; r < NRUNS; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_write(AW'($urandom_range(0, 15)), 16'($urandom));
            end
            make_plan(1'b1);
            do_run(int'($urandom_range(0, 16)), "run");
        end

        // Reset in the middle of a run, then rerun from intact memory.
        make_plan(1'b0);
        seen.delete();
        prog_len = (AW + 1)'(DEPTH);
        go = 1'b1;
        cycle();
        go = 1'b0;
        repeat ($urandom_range(4, 15)) cycle();
        check("midrun_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_outputs("midrun_reset");
        ref_status = 3'b000;
        n0 = seen.size();
        repeat (10) cycle();
        check("reset_no_repulse", 32'(seen.size()), 32'(n0));
        wait_stub_idle();
        make_plan(1'b0);
        do_run(int'(DEPTH), "after_reset");
        do_run(0, "final_len0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
